// File: rtl/quickq_array_ctrl.sv
// rtl/quickq_array_ctrl.sv - sequencing controller for one QuickQ sorted-array level
module quickq_array_ctrl #(
    parameter int ARRAY_SIZE = 16,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic              cmd_op,
    input  logic [31:0]       cmd_data,
    output logic              cmd_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic [7:0]        count,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_we,
    output logic [31:0]       bram_wdata,
    input  logic [31:0]       bram_rdata,
    output logic [2:0]        vr_mode,
    output logic [31:0]       vr_reg_out,
    output logic [7:0]        vr_array_cnt_in,
    input  logic [31:0]       vr_bram_insert,
    input  logic [31:0]       vr_to_register,
    input  logic [7:0]        vr_array_cnt_out
);

    localparam logic [7:0] SIZE = 8'(ARRAY_SIZE);

    typedef enum logic [3:0] {
        IDLE, ENQ_RD, ENQ_CMP, ENQ_TAIL,
        DEQ_RD, DEQ_HEAD, DEQ_SH_RD, DEQ_SH_WR, DEQ_DONE, RSP
    } state_t;

    state_t      state, state_next;
    logic [7:0]  count_q, count_next;
    logic [7:0]  idx_q, idx_next;
    logic [31:0] reg_q, reg_next;
    logic [31:0] out_q, out_next;
    logic        err_q, err_next;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [7:0] a);
        return ADDR_W'(a);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            reg_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_next;
            count_q <= count_next;
            idx_q   <= idx_next;
            reg_q   <= reg_next;
            out_q   <= out_next;
            err_q   <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count_q;
        idx_next   = idx_q;
        reg_next   = reg_q;
        out_next   = out_q;
        err_next   = err_q;
        bram_addr  = '0;
        bram_we    = 1'b0;
        bram_wdata = '0;
        vr_mode    = 3'b000;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    idx_next = '0;
                    out_next = '0;
                    err_next = 1'b0;
                    if (!cmd_op) begin
                        if (full) begin
                            err_next   = 1'b1;
                            state_next = RSP;
                        end else begin
                            reg_next   = cmd_data;
                            state_next = (count_q == 8'd0) ? ENQ_TAIL : ENQ_RD;
                        end
                    end else begin
                        if (empty) begin
                            err_next   = 1'b1;
                            state_next = RSP;
                        end else begin
                            state_next = DEQ_RD;
                        end
                    end
                end
            end
            ENQ_RD: begin
                bram_addr  = addr_of(idx_q);
                state_next = ENQ_CMP;
            end
            ENQ_CMP: begin
                // Smaller value stays in place, larger one rides on toward the tail
                vr_mode    = 3'b000;
                bram_addr  = addr_of(idx_q);
                bram_we    = 1'b1;
                bram_wdata = vr_bram_insert;
                reg_next   = vr_to_register;
                idx_next   = idx_q + 8'd1;
                state_next = (idx_q + 8'd1 == count_q) ? ENQ_TAIL : ENQ_RD;
            end
            ENQ_TAIL: begin
                vr_mode    = 3'b001;
                bram_addr  = addr_of(count_q);
                bram_we    = 1'b1;
                bram_wdata = reg_q;
                count_next = vr_array_cnt_out;
                state_next = RSP;
            end
            DEQ_RD: begin
                bram_addr  = '0;
                state_next = DEQ_HEAD;
            end
            DEQ_HEAD: begin
                vr_mode  = 3'b010;
                out_next = vr_to_register;
                if (count_q == 8'd1) begin
                    state_next = DEQ_DONE;
                end else begin
                    idx_next   = 8'd1;
                    state_next = DEQ_SH_RD;
                end
            end
            DEQ_SH_RD: begin
                bram_addr  = addr_of(idx_q);
                state_next = DEQ_SH_WR;
            end
            DEQ_SH_WR: begin
                bram_addr  = addr_of(idx_q - 8'd1);
                bram_we    = 1'b1;
                bram_wdata = bram_rdata;
                idx_next   = idx_q + 8'd1;
                state_next = (idx_q == count_q - 8'd1) ? DEQ_DONE : DEQ_SH_RD;
            end
            DEQ_DONE: begin
                vr_mode    = 3'b011;
                count_next = vr_array_cnt_out;
                state_next = RSP;
            end
            RSP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cmd_ready       = (state == IDLE);
    assign rsp_valid       = (state == RSP);
    assign rsp_data        = out_q;
    assign rsp_err         = err_q;
    assign count           = count_q;
    assign full            = (count_q == SIZE);
    assign empty           = (count_q == 8'd0);
    assign vr_reg_out      = reg_q;
    assign vr_array_cnt_in = count_q;

endmodule

// File: tb/tb_quickq_array_ctrl.sv
// tb/tb_quickq_array_ctrl.sv - self-checking bench for quickq_array_ctrl with BRAM and valueRouter models
module tb_quickq_array_ctrl;

    localparam int SIZE = 4;
    localparam int AW   = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_op;
    logic [31:0]   cmd_data;
    logic          cmd_ready;
    logic          rsp_valid;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic [7:0]    count;
    logic          full;
    logic          empty;
    logic [AW-1:0] bram_addr;
    logic          bram_we;
    logic [31:0]   bram_wdata;
    logic [31:0]   bram_rdata;
    logic [2:0]    vr_mode;
    logic [31:0]   vr_reg_out;
    logic [7:0]    vr_array_cnt_in;
    logic [31:0]   vr_bram_insert;
    logic [31:0]   vr_to_register;
    logic [7:0]    vr_array_cnt_out;

    always #5 clk = ~clk;

    quickq_array_ctrl #(.ARRAY_SIZE(SIZE), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .count(count), .full(full), .empty(empty),
        .bram_addr(bram_addr), .bram_we(bram_we), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
        .vr_mode(vr_mode), .vr_reg_out(vr_reg_out), .vr_array_cnt_in(vr_array_cnt_in),
        .vr_bram_insert(vr_bram_insert), .vr_to_register(vr_to_register),
        .vr_array_cnt_out(vr_array_cnt_out)
    );

    // BRAM with one-cycle read latency
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bram_we) mem[bram_addr] <= bram_wdata;
        bram_rdata <= mem[bram_addr];
    end

    // valueRouter behaviour
    assign vr_bram_insert   = (bram_rdata <= vr_reg_out) ? bram_rdata : vr_reg_out;
    assign vr_to_register   = (vr_mode == 3'b010) ? bram_rdata :
                              ((bram_rdata <= vr_reg_out) ? vr_reg_out : bram_rdata);
    assign vr_array_cnt_out = (vr_mode == 3'b001) ? vr_array_cnt_in + 8'd1 :
                              (vr_mode == 3'b011) ? vr_array_cnt_in - 8'd1 : vr_array_cnt_in;

    int we_cnt = 0;
    always @(posedge clk) if (bram_we) we_cnt <= we_cnt + 1;

    typedef struct {
        logic        op;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [7:0]  exp_cnt;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } sb_t;

    vec_t vecs [20];
    sb_t  sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   model_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int i;
        i = 0;
        while (!cmd_ready && i < 50) begin
            @(negedge clk);
            i++;
        end
        if (!cmd_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_cmd(input logic op, input logic [31:0] d, input logic [31:0] ed,
                          input logic ee, input logic [7:0] ec);
        sb_t e;
        int  lat;
        int  w0;
        bit  got;
        e.data = ed;
        e.err  = ee;
        e.lat  = ee ? 1 : 2 * model_cnt + 2;
        sb.push_back(e);
        @(negedge clk);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        w0        = we_cnt;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        if (!got) begin
            chk("rsp_timeout", 32'd0, 32'd1);
        end else begin
            chk("rsp_latency", 32'(lat), 32'(e.lat));
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("count", 32'(count), 32'(ec));
            if (ee) chk("err_no_write", 32'(we_cnt - w0), 32'd0);
        end
        @(negedge clk);
        chk("ready_after_rsp", 32'(cmd_ready), 32'd1);
        model_cnt = ec;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++)
            do_cmd(vecs[i].op, vecs[i].data, vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 32'd5, 32'd0, 1'b0, 8'd1};
        vecs[1]  = '{1'b0, 32'd2, 32'd0, 1'b0, 8'd2};
        vecs[2]  = '{1'b0, 32'd9, 32'd0, 1'b0, 8'd3};
        vecs[3]  = '{1'b1, 32'd0, 32'd2, 1'b0, 8'd2};
        vecs[4]  = '{1'b1, 32'd0, 32'd5, 1'b0, 8'd1};
        vecs[5]  = '{1'b1, 32'd0, 32'd9, 1'b0, 8'd0};
        vecs[6]  = '{1'b1, 32'd0, 32'd0, 1'b1, 8'd0};
        vecs[7]  = '{1'b0, 32'hF680D628, 32'd0, 1'b0, 8'd1};
        vecs[8]  = '{1'b0, 32'hF657C062, 32'd0, 1'b0, 8'd2};
        vecs[9]  = '{1'b0, 32'h39B034AC, 32'd0, 1'b0, 8'd3};
        vecs[10] = '{1'b0, 32'h39B034AB, 32'd0, 1'b0, 8'd4};
        vecs[11] = '{1'b0, 32'd1, 32'd0, 1'b1, 8'd4};
        vecs[12] = '{1'b1, 32'd0, 32'h39B034AB, 1'b0, 8'd3};
        vecs[13] = '{1'b1, 32'd0, 32'h39B034AC, 1'b0, 8'd2};
        vecs[14] = '{1'b1, 32'd0, 32'hF657C062, 1'b0, 8'd1};
        vecs[15] = '{1'b1, 32'd0, 32'hF680D628, 1'b0, 8'd0};
        vecs[16] = '{1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, 8'd1};
        vecs[17] = '{1'b0, 32'd0, 32'd0, 1'b0, 8'd2};
        vecs[18] = '{1'b1, 32'd0, 32'd0, 1'b0, 8'd1};
        vecs[19] = '{1'b1, 32'd0, 32'hFFFFFFFF, 1'b0, 8'd0};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_data  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_bram_we", 32'(bram_we), 32'd0);

        run_vecs(0, 3);
        chk("bram0_after_3enq", mem[0], 32'd2);
        chk("bram1_after_3enq", mem[1], 32'd5);
        chk("bram2_after_3enq", mem[2], 32'd9);
        run_vecs(3, 6);
        chk("empty_after_drain", 32'(empty), 32'd1);
        run_vecs(6, 11);
        chk("full_at_capacity", 32'(full), 32'd1);
        run_vecs(11, 12);
        chk("bram0_full", mem[0], 32'h39B034AB);
        chk("bram1_full", mem[1], 32'h39B034AC);
        chk("bram2_full", mem[2], 32'hF657C062);
        chk("bram3_full", mem[3], 32'hF680D628);
        chk("full_after_err", 32'(full), 32'd1);
        run_vecs(12, 20);

        do_cmd(1'b0, 32'd1, 32'd0, 1'b0, 8'd1);
        do_cmd(1'b0, 32'd2, 32'd0, 1'b0, 8'd2);
        do_cmd(1'b0, 32'd3, 32'd0, 1'b0, 8'd3);
        @(negedge clk);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_data  = 32'd7;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_we_before_reset", 32'(bram_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_bram_we", 32'(bram_we), 32'd0);
        chk("mid_reset_count", 32'(count), 32'd0);
        chk("mid_reset_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        model_cnt = 0;
        do_cmd(1'b1, 32'd0, 32'd0, 1'b1, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/quickq_array_ctrl.md
Name: quickq_array_ctrl

Overview:
- Sequencing controller directly upstream of valueRouter in one QuickQ sorted-array level.
- Accepts enqueue/dequeue commands and walks the level's BRAM one address per step.
- Drives valueRouter mode, register operand and count; consumes its compare/route results.
- Keeps the array sorted ascending (minimum at address 0) and returns dequeued values.

Parameters:
ARRAY_SIZE, 16, capacity of the level in entries (1..255)
ADDR_W, 8, BRAM address width (2**ADDR_W >= ARRAY_SIZE)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
cmd_valid  input  1  command request
cmd_op  input  1  0 = enqueue, 1 = dequeue
cmd_data  input  32  enqueue value, unsigned
cmd_ready  output  1  high only in IDLE
rsp_valid  output  1  one-cycle completion pulse
rsp_data  output  32  dequeued value; 0 for enqueue or error
rsp_err  output  1  enqueue when full, or dequeue when empty
count  output  8  current occupancy
full  output  1  count == ARRAY_SIZE
empty  output  1  count == 0
bram_addr  output  ADDR_W  BRAM address
bram_we  output  1  BRAM write enable
bram_wdata  output  32  BRAM write data
bram_rdata  input  32  BRAM read data, 1-cycle latency; also wired to valueRouter bram_out externally
vr_mode  output  3  valueRouter mode
vr_reg_out  output  32  carried register value to valueRouter
vr_array_cnt_in  output  8  equals count
vr_bram_insert  input  32  min(bram_out, reg_out) in mode 000
vr_to_register  input  32  max in mode 000; bram_out in mode 010
vr_array_cnt_out  input  8  cnt+1 in mode 001; cnt-1 in mode 011

Behaviour:
- Reset is asynchronous, active-low, fixed; one clock domain.
- Reset values: state IDLE, count 0, carried register 0, rsp_valid 0, rsp_data 0, rsp_err 0, bram_we 0, bram_addr 0, bram_wdata 0, vr_mode 000.
- Outputs after reset: cmd_ready=1, empty=1, full=0.
- Handshake: command is accepted when cmd_valid && cmd_ready.
- rsp_valid is a single-cycle pulse with no backpressure.
- cmd_ready returns high the cycle after rsp_valid.
- Let n = count at the accept cycle (cycle 0).
- Enqueue, n < ARRAY_SIZE:
  - Cycle 0 (IDLE): reg <= cmd_data; idx <= 0. Go to ENQ_TAIL if n == 0, else ENQ_RD.
  - ENQ_RD: bram_addr = idx, we = 0.
  - ENQ_CMP: vr_mode = 000, vr_reg_out = reg. Write vr_bram_insert to idx. reg <= vr_to_register; idx++. Go to ENQ_TAIL when the new idx == n, else ENQ_RD.
  - ENQ_TAIL: write reg to address n. vr_mode = 001; count <= vr_array_cnt_out.
  - RSP: rsp_valid at cycle 2n+2, rsp_err = 0.
- Dequeue, n > 0:
  - DEQ_RD: read address 0.
  - DEQ_HEAD: vr_mode = 010; out <= vr_to_register. If n == 1 go to DEQ_DONE, else idx <= 1.
  - DEQ_SH_RD / DEQ_SH_WR pairs: read idx, then write bram_rdata to idx-1; idx++. Stop after idx == n-1 is written down.
  - DEQ_DONE: vr_mode = 011; count <= vr_array_cnt_out.
  - RSP: rsp_valid at cycle 2n+2, rsp_data = out.
- Error cases (enqueue when full, or dequeue when empty):
  - No BRAM write, count unchanged.
  - rsp_valid at cycle 1 with rsp_err = 1, rsp_data = 0.
- bram_we is asserted only in ENQ_CMP, ENQ_TAIL and DEQ_SH_WR.
- Address 0..count-1 always holds a sorted array (unsigned ascending) when in IDLE.
- Comparison ties keep the existing entry nearer the head (FIFO among equal values).
- full and empty are derived combinationally from registered count.
- count never exceeds ARRAY_SIZE and never wraps below 0.
- cmd_valid outside IDLE is ignored; there is no queuing of commands.
- Reset asserted mid-operation:
  - Immediately returns to IDLE with count 0 and bram_we 0.
  - Partial BRAM contents are don't-care, since the queue reads as empty.

Test Plan:
- Reset -> cmd_ready=1, empty=1, full=0, count=0, rsp_valid=0, bram_we=0.
- Enqueue 5, 2, 9 -> rsp_valid at cycles 2, 4, 6 after each accept; BRAM[0..2] = 2, 5, 9; count=3. Then 3 dequeues -> rsp_data 2, 5, 9, each at cycle 2n+2; empty=1.
- Dequeue on empty -> rsp_valid at cycle 1, rsp_err=1, rsp_data=0, count=0, no bram_we pulse.
- ARRAY_SIZE=4:
  - Enqueue 0xF680D628, 0xF657C062, 0x39B034AC, 0x39B034AB -> full=1.
  - A 5th enqueue of 1 -> rsp_err=1, BRAM = 0x39B034AB, 0x39B034AC, 0xF657C062, 0xF680D628 unchanged.
- Enqueue 0xFFFFFFFF then 0 -> first dequeue returns 0, second 0xFFFFFFFF (unsigned order).
- Count=3, enqueue 7, drop rst_n during ENQ_CMP -> same cycle: bram_we=0, count=0, cmd_ready=1; next dequeue -> rsp_err=1.
